segment_transition_ctl: RTL and testbench

//  Decides which of the NumSegment modulation/STM segments the read side plays, and when it stops.

---
 rtl/segment_transition_ctl_pkg.sv | 24 ++
 rtl/segment_transition_ctl_if.sv | 33 +++
 rtl/segment_transition_ctl_transition_trigger.sv | 40 ++++
 rtl/segment_transition_ctl.sv | 108 ++++++++++
 tb/tb_segment_transition_ctl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/segment_transition_ctl_pkg.sv
// Shared types and constants for the segment transition controller.
// Mode codes match the register decoder's transition_mode field.
package segment_transition_ctl_pkg;

    localparam int NumSegment          = 2;
    localparam int SysTimeWidthDefault = 56;
    localparam int RepWidthDefault     = 16;

    // A REP register holding all-ones means the segment loops forever.
    localparam logic [RepWidthDefault-1:0] RepInfinite = '1;

    typedef enum logic [7:0] {
        TRANS_SYNC_IDX = 8'h00,
        TRANS_SYS_TIME = 8'h01,
        TRANS_GPIO     = 8'h02,
        TRANS_EXT      = 8'hf0
    } transition_mode_t;

    typedef logic [1:0] seg_state_t;
    localparam seg_state_t PLAY      = 2'd0;
    localparam seg_state_t WAIT_TRIG = 2'd1;
    localparam seg_state_t STOPPED   = 2'd2;

endpackage

// File: rtl/segment_transition_ctl_if.sv
// Settings, timing inputs and segment status between decoder/counters and the controller.
// master drives settings and timing; slave is the controller.
interface segment_transition_ctl_if
    import segment_transition_ctl_pkg::*;
#(
    parameter int SysTimeWidth = SysTimeWidthDefault,
    parameter int RepWidth     = RepWidthDefault
);
    logic                    update_settings;
    logic                    req_rd_segment;
    logic [7:0]              transition_mode;
    logic [63:0]             transition_value;
    logic [RepWidth-1:0]     rep0;
    logic [RepWidth-1:0]     rep1;
    logic [SysTimeWidth-1:0] sys_time;
    logic [3:0]              gpio_in;
    logic                    loop_end;
    logic                    segment;
    logic                    stop;
    logic                    swapped;

    modport master (
        output update_settings, req_rd_segment, transition_mode, transition_value,
               rep0, rep1, sys_time, gpio_in, loop_end,
        input  segment, stop, swapped
    );

    modport slave (
        input  update_settings, req_rd_segment, transition_mode, transition_value,
               rep0, rep1, sys_time, gpio_in, loop_end,
        output segment, stop, swapped
    );
endinterface

// File: rtl/segment_transition_ctl_transition_trigger.sv
// Purpose: evaluates the latched transition mode into a single-cycle fire flag.
// Latency: combinational fire; only the GPIO edge detector holds state.
// Backpressure: none; caller decides when fire is honoured.
module transition_trigger
    import segment_transition_ctl_pkg::*;
#(
    parameter int SysTimeWidth = SysTimeWidthDefault
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              mode,
    input  logic [SysTimeWidth-1:0] value,
    input  logic [SysTimeWidth-1:0] sys_time,
    input  logic [3:0]              gpio_in,
    input  logic                    loop_end,
    output logic                    fire,
    output logic                    mode_valid
);
    logic [3:0] gpio_prev;
    logic       gpio_rise;

    // Tracks every cycle so a level held before the wait never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) gpio_prev <= '0;
        else        gpio_prev <= gpio_in;
    end

    assign gpio_rise = gpio_in[value[1:0]] & ~gpio_prev[value[1:0]];

    always_comb begin
        fire       = 1'b0;
        mode_valid = 1'b1;
        case (mode)
            TRANS_SYNC_IDX, TRANS_EXT: fire = loop_end;
            TRANS_SYS_TIME:            fire = (sys_time >= value);
            TRANS_GPIO:                fire = gpio_rise;
            default:                   mode_valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/segment_transition_ctl.sv
// Purpose: picks the active mod/STM segment, swaps on trigger, stops when finite repeats expire.
// Latency: SEGMENT/SWAPPED/STOP update one cycle after the trigger or LOOP_END that causes them.
// Backpressure: none; UPDATE_SETTINGS is always accepted and overwrites any pending request.
module segment_transition_ctl
    import segment_transition_ctl_pkg::*;
#(
    parameter int SysTimeWidth = SysTimeWidthDefault,
    parameter int RepWidth     = RepWidthDefault
) (
    input  logic                     clk,
    input  logic                     rst_n,
    segment_transition_ctl_if.slave  bus
);
    seg_state_t              state, prev_state;
    logic                    req_seg;
    logic [7:0]              mode_q;
    logic [SysTimeWidth-1:0] value_q;
    logic [RepWidth-1:0]     rep0_q, rep1_q, rep_cnt, rep_active;
    logic                    ext_auto;
    logic                    seg_q, stop_q, swapped_q;
    logic                    fire, mode_valid, rep_inf;

    transition_trigger #(.SysTimeWidth(SysTimeWidth)) u_trigger (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode_q),
        .value      (value_q),
        .sys_time   (bus.sys_time),
        .gpio_in    (bus.gpio_in),
        .loop_end   (bus.loop_end),
        .fire       (fire),
        .mode_valid (mode_valid)
    );

    assign rep_active = seg_q ? rep1_q : rep0_q;
    assign rep_inf    = &rep_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PLAY;
            prev_state <= PLAY;
            req_seg    <= 1'b0;
            mode_q     <= '0;
            value_q    <= '0;
            rep0_q     <= '1;
            rep1_q     <= '1;
            rep_cnt    <= '0;
            ext_auto   <= 1'b0;
            seg_q      <= 1'b0;
            stop_q     <= 1'b0;
            swapped_q  <= 1'b0;
        end else begin
            swapped_q <= 1'b0;
            if (bus.update_settings) begin
                // A fresh request always beats whatever the old one was waiting for.
                req_seg  <= bus.req_rd_segment;
                mode_q   <= bus.transition_mode;
                value_q  <= bus.transition_value[SysTimeWidth-1:0];
                rep0_q   <= bus.rep0;
                rep1_q   <= bus.rep1;
                ext_auto <= (bus.transition_mode == TRANS_EXT);
                if (state != WAIT_TRIG) prev_state <= state;
                state <= WAIT_TRIG;
            end else begin
                case (state)
                    WAIT_TRIG: begin
                        if (!mode_valid) begin
                            state <= prev_state;
                        end else if (fire) begin
                            seg_q     <= req_seg;
                            swapped_q <= 1'b1;
                            rep_cnt   <= '0;
                            stop_q    <= 1'b0;
                            state     <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (bus.loop_end && !rep_inf) begin
                            if (rep_cnt == rep_active) begin
                                if (ext_auto) begin
                                    seg_q     <= ~seg_q;
                                    swapped_q <= 1'b1;
                                    rep_cnt   <= '0;
                                end else begin
                                    stop_q <= 1'b1;
                                    state  <= STOPPED;
                                end
                            end else begin
                                rep_cnt <= rep_cnt + RepWidth'(1);
                            end
                        end
                    end
                    STOPPED: ;
                    default: state <= PLAY;
                endcase
            end
        end
    end

    assign bus.segment = seg_q;
    assign bus.stop    = stop_q;
    assign bus.swapped = swapped_q;

    if (SysTimeWidth < 64) begin : g_value_hi
        logic unused_value_hi;
        assign unused_value_hi = ^bus.transition_value[63:SysTimeWidth];
    end
endmodule

// File: tb/tb_segment_transition_ctl.sv
// Directed bench for segment_transition_ctl: swap triggers, repetition stop, EXT auto-swap, reset.
module tb_segment_transition_ctl;
    import segment_transition_ctl_pkg::*;

    logic clk;
    logic rst_n;
    int   ncmp  = 0;
    int   nfail = 0;

    segment_transition_ctl_if #(.SysTimeWidth(56), .RepWidth(16)) bus ();

    segment_transition_ctl #(.SysTimeWidth(56), .RepWidth(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic seg, input logic stp, input logic swp);
        check({tag, ".segment"}, bus.segment, seg);
        check({tag, ".stop"},    bus.stop,    stp);
        check({tag, ".swapped"}, bus.swapped, swp);
    endtask

    task automatic update(input logic seg, input logic [7:0] mode, input logic [63:0] val,
                          input logic [15:0] r0, input logic [15:0] r1);
        bus.update_settings  = 1'b1;
        bus.req_rd_segment   = seg;
        bus.transition_mode  = mode;
        bus.transition_value = val;
        bus.rep0             = r0;
        bus.rep1             = r1;
        step();
        bus.update_settings  = 1'b0;
    endtask

    task automatic pulse_le();
        bus.loop_end = 1'b1;
        step();
        bus.loop_end = 1'b0;
    endtask

    logic ext_seg [6];
    logic ext_swp [6];

    initial begin
        rst_n                = 1'b0;
        bus.update_settings  = 1'b0;
        bus.req_rd_segment   = 1'b0;
        bus.transition_mode  = 8'h00;
        bus.transition_value = 64'd0;
        bus.rep0             = RepInfinite;
        bus.rep1             = RepInfinite;
        bus.sys_time         = 56'd0;
        bus.gpio_in          = 4'b0000;
        bus.loop_end         = 1'b0;
        step();
        step();
        check_out("reset", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();

        // 1: infinite REP0 after reset, LOOP_END never stops or swaps
        for (int i = 0; i < 5; i++) begin
            pulse_le();
            check_out("t1_inf_loop", 1'b0, 1'b0, 1'b0);
        end

        // 2: SYNC_IDX swap on LOOP_END ten cycles after the update
        update(1'b1, TRANS_SYNC_IDX, 64'd0, RepInfinite, RepInfinite);
        for (int i = 0; i < 9; i++) begin
            step();
            check_out("t2_wait", 1'b0, 1'b0, 1'b0);
        end
        pulse_le();
        check_out("t2_swap", 1'b1, 1'b0, 1'b1);
        step();
        check_out("t2_after", 1'b1, 1'b0, 1'b0);

        // 3a: SYS_TIME counting up to the target
        bus.sys_time = 56'd990;
        update(1'b0, TRANS_SYS_TIME, 64'd1000, RepInfinite, RepInfinite);
        for (int t = 991; t <= 1000; t++) begin
            bus.sys_time = 56'(t);
            check_out("t3a_wait", 1'b1, 1'b0, 1'b0);
            step();
        end
        check_out("t3a_swap", 1'b0, 1'b0, 1'b1);
        bus.sys_time = 56'd1001;
        step();
        check_out("t3a_after", 1'b0, 1'b0, 1'b0);

        // 3b: target already in the past fires on the first evaluated cycle
        bus.sys_time = 56'd900;
        update(1'b1, TRANS_SYS_TIME, 64'd5, RepInfinite, RepInfinite);
        check_out("t3b_plus1", 1'b0, 1'b0, 1'b0);
        step();
        check_out("t3b_plus2", 1'b1, 1'b0, 1'b1);

        // 4: GPIO[2] already high is not an edge; other pins are ignored
        bus.gpio_in = 4'b0100;
        step();
        step();
        update(1'b0, TRANS_GPIO, 64'd2, RepInfinite, RepInfinite);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("t4_held", 1'b1, 1'b0, 1'b0);
        end
        bus.gpio_in = 4'b0110;
        step();
        check_out("t4_other_pin", 1'b1, 1'b0, 1'b0);
        bus.gpio_in = 4'b0000;
        step();
        check_out("t4_low", 1'b1, 1'b0, 1'b0);
        bus.gpio_in = 4'b0100;
        step();
        check_out("t4_swap", 1'b0, 1'b0, 1'b1);

        // 5: REP1=2 gives three loops, then STOP sticks until a new swap
        update(1'b1, TRANS_SYNC_IDX, 64'd0, RepInfinite, 16'd2);
        pulse_le();
        check_out("t5_swap", 1'b1, 1'b0, 1'b1);
        pulse_le();
        check_out("t5_le1", 1'b1, 1'b0, 1'b0);
        pulse_le();
        check_out("t5_le2", 1'b1, 1'b0, 1'b0);
        pulse_le();
        check_out("t5_le3", 1'b1, 1'b1, 1'b0);
        pulse_le();
        check_out("t5_le4", 1'b1, 1'b1, 1'b0);
        pulse_le();
        check_out("t5_le5", 1'b1, 1'b1, 1'b0);
        update(1'b0, TRANS_SYNC_IDX, 64'd0, RepInfinite, RepInfinite);
        check_out("t5_wait_stop", 1'b1, 1'b1, 1'b0);
        pulse_le();
        check_out("t5_reswap", 1'b0, 1'b0, 1'b1);

        // 6: EXT auto-swap with REP0=0, REP1=1 -> loops on 0,1,1,0,1,1
        ext_seg = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        ext_swp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        update(1'b0, TRANS_EXT, 64'd0, 16'd0, 16'd1);
        for (int i = 0; i < 6; i++) begin
            pulse_le();
            check_out($sformatf("t6_ext%0d", i), ext_seg[i], 1'b0, ext_swp[i]);
        end

        // Unknown mode code: request dropped, back to PLAY, EXT auto-swap off
        update(1'b0, 8'h55, 64'd0, RepInfinite, RepInfinite);
        pulse_le();
        check_out("t6_bad_mode", 1'b1, 1'b0, 1'b0);
        pulse_le();
        check_out("t6_bad_mode_play", 1'b1, 1'b0, 1'b0);

        // Last write wins: the SYNC_IDX request is replaced by an unreachable time
        update(1'b0, TRANS_SYNC_IDX, 64'd0, RepInfinite, RepInfinite);
        update(1'b0, TRANS_SYS_TIME, 64'h00ff_ffff_ffff_ffff, RepInfinite, RepInfinite);
        pulse_le();
        check_out("t6_overwrite", 1'b1, 1'b0, 1'b0);

        // Reset while waiting discards the request
        update(1'b0, TRANS_SYNC_IDX, 64'd0, RepInfinite, RepInfinite);
        rst_n = 1'b0;
        #2;
        check_out("t6_rst_async", 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        pulse_le();
        check_out("t6_rst_no_swap", 1'b0, 1'b0, 1'b0);
        step();
        check_out("t6_rst_idle", 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
